// File: rtl/word_cipher_pkg.sv
// Shared key, Polybius-square type and lookup helpers for the word cipher pair.
// The square is built from SEC_KEY at elaboration time; only the lookups become logic.
package word_cipher_pkg;

    localparam int KEY_LEN = 7;
    localparam int MAX_KEY = 25;
    localparam logic [8*KEY_LEN-1:0] SEC_KEY = "KEYWORD";
    localparam logic [7:0] INVALID_CHAR = 8'h3F;

    typedef logic [24:0][7:0]      square_t;
    typedef logic [8*MAX_KEY-1:0]  key_t;

    // Key letters first (first character in the most significant byte), then the rest of A-Z; J folds onto I.
    function automatic square_t build_square(input key_t key, input int key_len);
        square_t     sq;
        logic [25:0] used;
        logic [7:0]  c;
        int          n;
        int          idx;
        sq   = '0;
        used = '0;
        n    = 0;
        for (int i = 0; i < MAX_KEY; i++) begin
            if (i < key_len) begin
                c = key[8*(key_len-1-i) +: 8];
                if (c == "J") c = "I";
                if (c >= "A" && c <= "Z") begin
                    idx = int'(c) - 65;
                    if (!used[idx[4:0]] && n < 25) begin
                        sq[n[4:0]]      = c;
                        used[idx[4:0]]  = 1'b1;
                        n++;
                    end
                end
            end
        end
        for (int k = 0; k < 26; k++) begin
            c = 8'(65 + k);
            if (c != "J" && !used[k[4:0]] && n < 25) begin
                sq[n[4:0]]  = c;
                used[k[4:0]] = 1'b1;
                n++;
            end
        end
        return sq;
    endfunction

    function automatic logic [7:0] char_to_code(input square_t sq, input logic [7:0] ch);
        logic [7:0] up;
        logic [7:0] code;
        up = ch;
        if (ch >= "a" && ch <= "z") up = ch - 8'd32;
        if (up == "J") up = "I";
        code = 8'd0;
        if (up >= "A" && up <= "Z") begin
            for (int p = 0; p < 25; p++) begin
                if (sq[p[4:0]] == up) code = 8'((p / 5 + 1) * 10 + (p % 5) + 1);
            end
        end
        return code;
    endfunction

    function automatic logic [7:0] code_to_char(input square_t sq, input logic [7:0] code);
        logic [7:0] tens;
        logic [7:0] units;
        int         pos;
        tens  = code / 8'd10;
        units = code % 8'd10;
        pos   = (int'(tens) - 1) * 5 + int'(units) - 1;
        if (tens >= 8'd1 && tens <= 8'd5 && units >= 8'd1 && units <= 8'd5)
            return sq[pos[4:0]];
        return INVALID_CHAR;
    endfunction

endpackage

// File: rtl/decryptor.sv
// Stage 2: per-code square lookup back to uppercase ASCII, '?' for unmapped codes.
module decryptor
    import word_cipher_pkg::*;
#(
    parameter int MSG_LEN = 5,
    parameter int SEC_LEN = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] text_in  [0:MSG_LEN-1],
    output logic       out_valid,
    output logic [7:0] text_out [0:MSG_LEN-1]
);

    localparam square_t SQUARE = build_square(key_t'(SEC_KEY), SEC_LEN);

    logic [7:0] letter [0:MSG_LEN-1];

    for (genvar g = 0; g < MSG_LEN; g++) begin : g_lookup
        assign letter[g] = code_to_char(SQUARE, text_in[g]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) text_out[i] <= 8'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < MSG_LEN; i++) text_out[i] <= letter[i];
            end
        end
    end

endmodule

// File: rtl/encryptor.sv
// Stage 1: per-character letter-to-code lookup into one register stage.
module encryptor
    import word_cipher_pkg::*;
#(
    parameter int MSG_LEN = 5,
    parameter int SEC_LEN = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] text_in  [0:MSG_LEN-1],
    output logic       out_valid,
    output logic [7:0] text_out [0:MSG_LEN-1]
);

    localparam square_t SQUARE = build_square(key_t'(SEC_KEY), SEC_LEN);

    logic [7:0] code [0:MSG_LEN-1];

    for (genvar g = 0; g < MSG_LEN; g++) begin : g_lookup
        assign code[g] = char_to_code(SQUARE, text_in[g]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) text_out[i] <= 8'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < MSG_LEN; i++) text_out[i] <= code[i];
            end
        end
    end

endmodule

// File: rtl/word_enc_dec.sv
// Encrypt-then-decrypt loopback: two registered stages, one message per cycle.
module word_enc_dec #(
    parameter int MSG_LEN = 5,
    parameter int SEC_LEN = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] text_in  [0:MSG_LEN-1],
    output logic       enc_valid,
    output logic [7:0] enc_text [0:MSG_LEN-1],
    output logic       dec_valid,
    output logic [7:0] dec_text [0:MSG_LEN-1]
);

    encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_encryptor (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .text_in   (text_in),
        .out_valid (enc_valid),
        .text_out  (enc_text)
    );

    decryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u_decryptor (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (enc_valid),
        .text_in   (enc_text),
        .out_valid (dec_valid),
        .text_out  (dec_text)
    );

endmodule

// File: tb/tb_word_enc_dec.sv
// Self-checking bench for word_enc_dec plus a standalone decryptor instance.
module tb_word_enc_dec;

    localparam int N = 5;
    typedef logic [7:0] msg_t [0:N-1];

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    msg_t text_in;
    logic enc_valid;
    msg_t enc_text;
    logic dec_valid;
    msg_t dec_text;

    logic d_valid;
    msg_t d_in;
    logic d_out_valid;
    msg_t d_out;

    int n_tests = 0;
    int n_fail  = 0;

    string sq_model;

    int exp_enc_valid;
    int exp_dec_valid;
    int exp_enc [N];
    int exp_dec [N];
    msg_t last_msg;

    always #5 clk = ~clk;

    word_enc_dec #(.MSG_LEN(N), .SEC_LEN(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .text_in   (text_in),
        .enc_valid (enc_valid),
        .enc_text  (enc_text),
        .dec_valid (dec_valid),
        .dec_text  (dec_text)
    );

    decryptor #(.MSG_LEN(N), .SEC_LEN(7)) u_dec_only (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d_valid),
        .text_in   (d_in),
        .out_valid (d_out_valid),
        .text_out  (d_out)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= "a" && c <= "z") u = c - 8'd32;
        if (u == "J") u = "I";
        return u;
    endfunction

    function automatic int model_enc(input logic [7:0] c);
        logic [7:0] u;
        u = fold(c);
        if (!(u >= "A" && u <= "Z")) return 0;
        for (int p = 0; p < 25; p++)
            if (sq_model[p] == u) return (p / 5 + 1) * 10 + (p % 5) + 1;
        return -1;
    endfunction

    function automatic int model_roundtrip(input logic [7:0] c);
        logic [7:0] u;
        u = fold(c);
        return (u >= "A" && u <= "Z") ? int'(u) : 63;
    endfunction

    function automatic int model_dec(input int code);
        int t;
        int u;
        t = code / 10;
        u = code % 10;
        if (t >= 1 && t <= 5 && u >= 1 && u <= 5) return int'(sq_model[(t - 1) * 5 + u - 1]);
        return 63;
    endfunction

    function automatic void str2msg(input string s, output msg_t m);
        for (int i = 0; i < N; i++) m[i] = s[i];
    endfunction

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 3))
            0:       return 8'($urandom_range(0, 255));
            1:       return 8'($urandom_range(65, 90));
            2:       return 8'($urandom_range(97, 122));
            default: return ($urandom_range(0, 1) == 1) ? "J" : "j";
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, " enc_valid"}, int'(enc_valid), exp_enc_valid);
        check({tag, " dec_valid"}, int'(dec_valid), exp_dec_valid);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s enc[%0d]", tag, i), int'(enc_text[i]), exp_enc[i]);
            check($sformatf("%s dec[%0d]", tag, i), int'(dec_text[i]), exp_dec[i]);
        end
    endtask

    task automatic clear_model();
        exp_enc_valid = 0;
        exp_dec_valid = 0;
        for (int i = 0; i < N; i++) begin
            exp_enc[i] = 0;
            exp_dec[i] = 0;
        end
    endtask

    // One clock: apply inputs, advance the message-level expectation, then compare.
    task automatic cycle(input string tag, input logic v, input msg_t m);
        in_valid = v;
        text_in  = m;
        @(posedge clk);
        #1;
        exp_dec_valid = exp_enc_valid;
        if (exp_enc_valid != 0)
            for (int i = 0; i < N; i++) exp_dec[i] = model_roundtrip(last_msg[i]);
        exp_enc_valid = int'(v);
        if (v) begin
            for (int i = 0; i < N; i++) exp_enc[i] = model_enc(m[i]);
            last_msg = m;
        end
        check_all(tag);
    endtask

    task automatic rand_msg(output msg_t m);
        for (int i = 0; i < N; i++) m[i] = rand_char();
    endtask

    msg_t m;
    msg_t prev_d;

    initial begin
        sq_model = "KEYWORDABCFGHILMNPQSTUVXZ";
        rst_n    = 1'b0;
        in_valid = 1'b0;
        d_valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            text_in[i] = 8'd0;
            d_in[i]    = 8'd0;
            last_msg[i] = 8'd0;
        end
        clear_model();

        #3;
        check_all("reset");
        check("dec_only valid reset", int'(d_out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_release");

        d_in[0] = 8'd0; d_in[1] = 8'd10; d_in[2] = 8'd56; d_in[3] = 8'd61; d_in[4] = 8'd255;
        d_valid = 1'b1;
        @(posedge clk);
        #1;
        check("dec_only valid", int'(d_out_valid), 1);
        for (int i = 0; i < N; i++) check($sformatf("dec_only bad[%0d]", i), int'(d_out[i]), 63);
        d_in[0] = 8'd22; d_in[1] = 8'd23; d_in[2] = 8'd11; d_in[3] = 8'd55; d_in[4] = 8'd34;
        @(posedge clk);
        #1;
        check("dec_only 22", int'(d_out[0]), int'("D"));
        check("dec_only 23", int'(d_out[1]), int'("A"));
        check("dec_only 11", int'(d_out[2]), int'("K"));
        check("dec_only 55", int'(d_out[3]), int'("Z"));
        check("dec_only 34", int'(d_out[4]), int'("I"));
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) d_in[i] = 8'($urandom_range(0, 66));
            prev_d = d_in;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                check($sformatf("dec_only rnd[%0d] code %0d", i, prev_d[i]), int'(d_out[i]), model_dec(int'(prev_d[i])));
        end
        d_valid = 1'b0;
        for (int i = 0; i < N; i++) d_in[i] = 8'd0;
        @(posedge clk);
        #1;
        check("dec_only valid drop", int'(d_out_valid), 0);
        for (int i = 0; i < N; i++)
            check($sformatf("dec_only hold[%0d]", i), int'(d_out[i]), model_dec(int'(prev_d[i])));

        str2msg("HELLO", m);
        cycle("hello", 1'b1, m);
        check("hello enc0", int'(enc_text[0]), 33);
        check("hello enc1", int'(enc_text[1]), 12);
        check("hello enc2", int'(enc_text[2]), 35);
        check("hello enc3", int'(enc_text[3]), 35);
        check("hello enc4", int'(enc_text[4]), 15);
        rand_msg(m);
        cycle("hello+2", 1'b0, m);
        check("hello dec_valid", int'(dec_valid), 1);
        check("hello enc_valid low", int'(enc_valid), 0);
        check("hello dec0", int'(dec_text[0]), int'("H"));
        check("hello dec4", int'(dec_text[4]), int'("O"));

        str2msg("jk!zO", m);
        cycle("fold", 1'b1, m);
        check("fold enc0", int'(enc_text[0]), 34);
        check("fold enc1", int'(enc_text[1]), 11);
        check("fold enc2", int'(enc_text[2]), 0);
        check("fold enc3", int'(enc_text[3]), 55);
        check("fold enc4", int'(enc_text[4]), 15);
        rand_msg(m);
        cycle("fold+2", 1'b0, m);
        check("fold dec0", int'(dec_text[0]), int'("I"));
        check("fold dec2", int'(dec_text[2]), int'("?"));

        str2msg("ABCDE", m);
        cycle("b2b1", 1'b1, m);
        check("b2b1 enc0", int'(enc_text[0]), 23);
        check("b2b1 enc3", int'(enc_text[3]), 22);
        check("b2b1 enc4", int'(enc_text[4]), 12);
        str2msg("VWXYZ", m);
        cycle("b2b2", 1'b1, m);
        check("b2b2 enc0", int'(enc_text[0]), 53);
        check("b2b2 enc1", int'(enc_text[1]), 14);
        check("b2b2 enc2", int'(enc_text[2]), 54);
        check("b2b2 enc3", int'(enc_text[3]), 13);
        check("b2b1 dec1", int'(dec_text[1]), int'("B"));
        rand_msg(m);
        cycle("b2b3", 1'b0, m);
        check("b2b2 dec0", int'(dec_text[0]), int'("V"));
        check("b2b2 dec1", int'(dec_text[1]), int'("W"));
        for (int k = 0; k < 3; k++) begin
            rand_msg(m);
            cycle("hold", 1'b0, m);
        end

        rand_msg(m);
        cycle("pre_rst1", 1'b1, m);
        rand_msg(m);
        cycle("pre_rst2", 1'b1, m);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        clear_model();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_release");
        for (int k = 0; k < 2; k++) begin
            rand_msg(m);
            cycle("after_rst", 1'b0, m);
        end

        for (int b = 0; b < 256; b += N) begin
            for (int i = 0; i < N; i++) m[i] = 8'((b + i) & 255);
            cycle("exhaustive", 1'b1, m);
        end

        for (int k = 0; k < 300; k++) begin
            rand_msg(m);
            cycle("random", 1'($urandom_range(0, 3) != 0), m);
        end
        rand_msg(m);
        cycle("flush1", 1'b0, m);
        cycle("flush2", 1'b0, m);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
